approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
- Downstream consumer of the 8x8 approximate multipliers (e.g. Mult_8x8_* variants).
- Accepts operand pairs A, B and the approximate product R over a valid/ready handshake.
- Recomputes the exact product internally and accumulates error statistics over a programmed number of samples: sum of error distance, maximum error distance, count of erroneous samples.
- Used in silicon-level characterisation of approximate multiplier variants.

Parameters:
- CNT_W, 16, width of the sample-count and erroneous-sample counters; max samples per run = 2^CNT_W - 1
- SUM_W, 16+CNT_W, width of the error-distance accumulator (derived; must not be overridden smaller)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: clear statistics, latch num_samples, begin run
- num_samples  input  CNT_W  samples to accept in this run; sampled only on accepted start
- in_valid  input  1  A/B/R beat valid
- in_ready  output  1  block can accept a beat
- A  input  8  multiplicand fed to the approximate multiplier
- B  input  8  multiplier operand fed to the approximate multiplier
- R  input  16  approximate product produced for A, B
- busy  output  1  run in progress (RUN or DRAIN state)
- done  output  1  statistics final and stable
- sum_ed  output  SUM_W  sum of |A*B - R| over accepted samples
- max_ed  output  16  maximum |A*B - R| seen
- err_cnt  output  CNT_W  number of samples with R != A*B

Behaviour:
- Reset: state IDLE; in_ready, busy, done = 0; sum_ed, max_ed, err_cnt = 0; internal counters and pipeline valids = 0.
- Reset asserted mid-run: same as above, with immediate effect. Partial statistics are discarded.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: clear sum_ed/max_ed/err_cnt/accepted count, latch num_samples, go to RUN. done drops on the same edge.
  - start in RUN/DRAIN: ignored.
  - RUN: in_ready = 1 while accepted < num_samples. A beat transfers when in_valid & in_ready.
  - Beat that makes accepted == num_samples: in_ready = 0 from the next cycle; go to DRAIN.
  - num_samples = 0: RUN to DRAIN on the next edge, no beats accepted.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE. done = 1 and holds until the next start or reset.
- Pipeline, 2 stages:
  - Stage 1, on the transfer edge: register ed = |A*B - R| (16-bit unsigned, exact 16-bit product), nz = (ed != 0), v1.
  - Stage 2, edge after: if v1, sum_ed += ed; max_ed = max(max_ed, ed); err_cnt += nz.
- Latency: last beat transfers at edge t; accumulators final at t+1; DRAIN to DONE at t+2 (done visible after edge t+2).
- Widths: SUM_W guarantees no overflow (65025 * (2^CNT_W - 1) < 2^SUM_W). No saturation logic required.
- in_valid while in_ready = 0: beat not consumed. Beats after num_samples reached are never accepted.
- Outputs are registered; stats are readable at any time but only guaranteed final when done = 1.

Optional Feature:
- Macro ERR_MON_SQ_EN.
- Defined: adds output sum_sq [32+CNT_W-1:0], the accumulated ed*ed, updated in stage 2 alongside sum_ed. It is reset and cleared on start exactly like sum_ed, and adds no latency.
- Undefined: port and squarer absent. All other behaviour is identical.

Test Plan:
- num_samples=4, beats (1,1,1), (2,3,6), (15,15,225), (255,255,65025) back-to-back -> done after drain; sum_ed=0, max_ed=0, err_cnt=0; in_ready low after 4th beat.
- num_samples=2, beats (3,5,R=14), (10,10,R=104) -> sum_ed=5, max_ed=4, err_cnt=2. With ERR_MON_SQ_EN: sum_sq=17.
- num_samples=1, beat (255,255,R=0) -> sum_ed=65025, max_ed=65025, err_cnt=1; done asserted 2 edges after the transfer.
- num_samples=3 with in_valid toggling 1,0,0,1,0,1,1,1 -> exactly 3 beats accepted; 4th valid beat not consumed (in_ready=0).
- num_samples=0 -> done after 2 edges; all stats 0. Second start while busy is ignored: num_samples is not re-latched and stats are not cleared.
- Reset asserted after 2 of 5 beats -> all outputs 0 immediately, state IDLE. A fresh start with num_samples=1, beat (4,4,R=12) -> sum_ed=4, err_cnt=1.

Source files
------------

// File: rtl/approx_mult_err_monitor_if.sv
// Operand/product beat bus between an approximate-multiplier source and
// the error monitor. The source (master) drives A, B, R and in_valid; the
// monitor (slave) answers with in_ready. A beat transfers on a rising clock
// edge where in_valid and in_ready are both high.
interface approx_mult_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] R;

  modport master (output in_valid, output A, output B, output R, input in_ready);
  modport slave  (input in_valid, input A, input B, input R, output in_ready);
endinterface

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for 8x8 approximate multipliers.
// Each accepted beat carries operands A, B and the approximate product R.
// The monitor recomputes A*B exactly, forms the error distance
// ed = |A*B - R| and accumulates the sum, the maximum and the number of
// non-zero errors over a programmed number of samples.
//
// Optional build macro ERR_MON_SQ_EN adds the sum_sq output, which is the
// running sum of ed*ed, updated in the same stage as sum_ed.
//
// SUM_W is derived from CNT_W; it must stay at least 16+CNT_W so that the
// worst case 65025 * (2^CNT_W - 1) cannot overflow the accumulator.
module approx_mult_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 16 + CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_samples,
  approx_mult_err_monitor_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [SUM_W-1:0]      sum_ed,
  output logic [15:0]           max_ed,
  output logic [CNT_W-1:0]      err_cnt
`ifdef ERR_MON_SQ_EN
  ,
  output logic [32+CNT_W-1:0]   sum_sq
`endif
);

  localparam int SQ_W = 32 + CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] accepted_inc;
  logic             in_ready_q;

  logic             start_ok;
  logic             xfer;
  logic [15:0]      prod;
  logic [15:0]      ed_next;

  logic             v1;
  logic [15:0]      ed1;
  logic             nz1;

  assign bus.in_ready = in_ready_q;

  // Exact product, error distance of the offered beat and the accept conditions.
  always_comb begin
    start_ok     = start && ((state == IDLE) || (state == DONE));
    xfer         = bus.in_valid && in_ready_q;
    accepted_inc = accepted + 1'b1;
    prod         = 16'(bus.A) * 16'(bus.B);
    ed_next      = 16'd0;
    if (prod >= bus.R) begin
      ed_next = prod - bus.R;
    end else begin
      ed_next = bus.R - prod;
    end
  end

  // Run control: counts accepted beats, owns in_ready/busy/done, waits for
  // the pipeline to empty before declaring the statistics final.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      target     <= '0;
      accepted   <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (start_ok) begin
      state      <= RUN;
      target     <= num_samples;
      accepted   <= '0;
      in_ready_q <= (num_samples != '0);
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (xfer) begin
            accepted <= accepted_inc;
            if (accepted_inc == target) begin
              in_ready_q <= 1'b0;
              state      <= DRAIN;
            end
          end else if (accepted == target) begin
            in_ready_q <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (!v1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Two-stage datapath: stage 1 registers the error distance of a
  // transferred beat, stage 2 folds it into the statistics. A start clears
  // the statistics; it can only be accepted when the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      ed1     <= '0;
      nz1     <= 1'b0;
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
`ifdef ERR_MON_SQ_EN
      sum_sq  <= '0;
`endif
    end else begin
      v1 <= xfer;
      if (xfer) begin
        ed1 <= ed_next;
        nz1 <= (ed_next != 16'd0);
      end
      if (start_ok) begin
        sum_ed  <= '0;
        max_ed  <= '0;
        err_cnt <= '0;
`ifdef ERR_MON_SQ_EN
        sum_sq  <= '0;
`endif
      end else if (v1) begin
        sum_ed  <= sum_ed + SUM_W'(ed1);
        err_cnt <= err_cnt + CNT_W'(nz1);
        if (ed1 > max_ed) begin
          max_ed <= ed1;
        end
`ifdef ERR_MON_SQ_EN
        sum_sq  <= sum_sq + SQ_W'(32'(ed1) * 32'(ed1));
`endif
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed self-checking bench for approx_mult_err_monitor.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at that same point, well away from the active edge.
// Build with ERR_MON_SQ_EN defined to also check sum_sq.
module tb_approx_mult_err_monitor;

  localparam int CNT_W = 16;
  localparam int SUM_W = 16 + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum_ed;
  logic [15:0]      max_ed;
  logic [CNT_W-1:0] err_cnt;
`ifdef ERR_MON_SQ_EN
  logic [32+CNT_W-1:0] sum_sq;
`endif

  int errors = 0;
  int checks = 0;

  approx_mult_err_monitor_if bus_if ();

  approx_mult_err_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .bus         (bus_if.slave),
    .busy        (busy),
    .done        (done),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .err_cnt     (err_cnt)
`ifdef ERR_MON_SQ_EN
    ,
    .sum_sq      (sum_sq)
`endif
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic startRun(input logic [CNT_W-1:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start       = 1'b0;
  endtask

  // Offer one beat and hold it until it transfers, within a cycle budget.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] r);
    bit taken;
    taken = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.A        = a;
    bus_if.B        = b;
    bus_if.R        = r;
    for (int n = 0; n < 20 && !taken; n++) begin
      if (bus_if.in_ready) taken = 1'b1;
      tick();
    end
    bus_if.in_valid = 1'b0;
    checkOutput("beat_taken", 64'(taken), 64'd1);
  endtask

  // After a final transfer: done must be low one edge later and high two edges later.
  task automatic drainCheck(input string tag);
    tick();
    checkOutput({tag, "_done_t1"}, 64'(done), 64'd0);
    tick();
    checkOutput({tag, "_done_t2"}, 64'(done), 64'd1);
    checkOutput({tag, "_busy_t2"}, 64'(busy), 64'd0);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done_wait"}, 64'(done), 64'd1);
  endtask

  logic [7:0]  va [4];
  logic [7:0]  vb [4];
  logic [15:0] vr [4];
  logic [7:0]  pattern;
  int          seen;

  // Directed sequence covering exact, erroneous, throttled, empty,
  // ignored-restart and mid-run reset scenarios.
  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    num_samples     = '0;
    bus_if.in_valid = 1'b0;
    bus_if.A        = '0;
    bus_if.B        = '0;
    bus_if.R        = '0;
    tick();
    tick();

    checkOutput("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    checkOutput("rst_busy",     64'(busy),    64'd0);
    checkOutput("rst_done",     64'(done),    64'd0);
    checkOutput("rst_sum_ed",   64'(sum_ed),  64'd0);
    checkOutput("rst_max_ed",   64'(max_ed),  64'd0);
    checkOutput("rst_err_cnt",  64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Four exact products back to back.
    $display("[TB] exact products, 4 samples");
    va = '{8'd1, 8'd2, 8'd15, 8'd255};
    vb = '{8'd1, 8'd3, 8'd15, 8'd255};
    vr = '{16'd1, 16'd6, 16'd225, 16'd65025};
    startRun(16'd4);
    checkOutput("t1_in_ready_run", 64'(bus_if.in_ready), 64'd1);
    checkOutput("t1_busy_run",     64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.A        = va[i];
      bus_if.B        = vb[i];
      bus_if.R        = vr[i];
      tick();
    end
    bus_if.in_valid = 1'b0;
    checkOutput("t1_in_ready_after4", 64'(bus_if.in_ready), 64'd0);
    checkOutput("t1_busy_drain",      64'(busy), 64'd1);
    drainCheck("t1");
    checkOutput("t1_sum_ed",  64'(sum_ed),  64'd0);
    checkOutput("t1_max_ed",  64'(max_ed),  64'd0);
    checkOutput("t1_err_cnt", 64'(err_cnt), 64'd0);

    // Two erroneous samples: ed 1 and 4.
    $display("[TB] two erroneous samples");
    startRun(16'd2);
    checkOutput("t2_done_cleared", 64'(done), 64'd0);
    applyStimulus(8'd3, 8'd5, 16'd14);
    applyStimulus(8'd10, 8'd10, 16'd104);
    drainCheck("t2");
    checkOutput("t2_sum_ed",  64'(sum_ed),  64'd5);
    checkOutput("t2_max_ed",  64'(max_ed),  64'd4);
    checkOutput("t2_err_cnt", 64'(err_cnt), 64'd2);
`ifdef ERR_MON_SQ_EN
    checkOutput("t2_sum_sq",  64'(sum_sq),  64'd17);
`endif

    // Worst-case single error distance.
    $display("[TB] maximum error distance");
    startRun(16'd1);
    checkOutput("t3_sum_cleared", 64'(sum_ed), 64'd0);
    applyStimulus(8'd255, 8'd255, 16'd0);
    drainCheck("t3");
    checkOutput("t3_sum_ed",  64'(sum_ed),  64'd65025);
    checkOutput("t3_max_ed",  64'(max_ed),  64'd65025);
    checkOutput("t3_err_cnt", 64'(err_cnt), 64'd1);
`ifdef ERR_MON_SQ_EN
    checkOutput("t3_sum_sq",  64'(sum_sq),  64'd4228250625);
`endif

    // Gapped valid pattern 1,0,0,1,0,1,1,1; each offered beat has ed = 1.
    $display("[TB] gapped valid, 3 samples");
    startRun(16'd3);
    pattern = 8'b1110_1001;
    seen    = 0;
    for (int i = 0; i < 8; i++) begin
      bus_if.in_valid = pattern[i];
      bus_if.A        = 8'(i + 1);
      bus_if.B        = 8'd2;
      bus_if.R        = 16'(2 * (i + 1) + 1);
      if (pattern[i] && bus_if.in_ready) seen++;
      tick();
    end
    checkOutput("t4_beats_seen",      64'(seen), 64'd3);
    checkOutput("t4_in_ready_blocked", 64'(bus_if.in_ready), 64'd0);
    bus_if.in_valid = 1'b0;
    waitDone("t4");
    checkOutput("t4_sum_ed",  64'(sum_ed),  64'd3);
    checkOutput("t4_max_ed",  64'(max_ed),  64'd1);
    checkOutput("t4_err_cnt", 64'(err_cnt), 64'd3);

    // Empty run completes two edges after start.
    $display("[TB] zero samples");
    startRun(16'd0);
    checkOutput("t5_in_ready_zero", 64'(bus_if.in_ready), 64'd0);
    checkOutput("t5_done_t1", 64'(done), 64'd0);
    tick();
    checkOutput("t5_done_t1b", 64'(done), 64'd0);
    tick();
    checkOutput("t5_done_t2",  64'(done),    64'd1);
    checkOutput("t5_sum_ed",   64'(sum_ed),  64'd0);
    checkOutput("t5_err_cnt",  64'(err_cnt), 64'd0);

    // A start during a run is ignored: no re-latch, no clear.
    $display("[TB] restart while busy");
    startRun(16'd2);
    applyStimulus(8'd3, 8'd5, 16'd14);
    startRun(16'd5);
    applyStimulus(8'd10, 8'd10, 16'd104);
    waitDone("t5b");
    checkOutput("t5b_sum_ed",   64'(sum_ed),  64'd5);
    checkOutput("t5b_err_cnt",  64'(err_cnt), 64'd2);
    checkOutput("t5b_in_ready", 64'(bus_if.in_ready), 64'd0);

    // Reset in the middle of a 5-sample run.
    $display("[TB] reset mid-run");
    startRun(16'd5);
    applyStimulus(8'd3, 8'd5, 16'd14);
    applyStimulus(8'd3, 8'd5, 16'd14);
    checkOutput("t6_sum_pre",  64'(sum_ed), 64'd1);
    checkOutput("t6_busy_pre", 64'(busy),   64'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("t6_rst_busy",     64'(busy),    64'd0);
    checkOutput("t6_rst_done",     64'(done),    64'd0);
    checkOutput("t6_rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    checkOutput("t6_rst_sum_ed",   64'(sum_ed),  64'd0);
    checkOutput("t6_rst_max_ed",   64'(max_ed),  64'd0);
    checkOutput("t6_rst_err_cnt",  64'(err_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    startRun(16'd1);
    applyStimulus(8'd4, 8'd4, 16'd12);
    waitDone("t6");
    checkOutput("t6_sum_ed",  64'(sum_ed),  64'd4);
    checkOutput("t6_max_ed",  64'(max_ed),  64'd4);
    checkOutput("t6_err_cnt", 64'(err_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
